// File: rtl/opl3_pkg.sv
// Shared types for the OPL3 register-write path: the downstream write transaction,
// the buffered host write entry and the host-port pacing FSM states.
package opl3_pkg;

  localparam int unsigned REG_FILE_DATA_WIDTH = 8;
  localparam int unsigned REG_FILE_ADDR_WIDTH = 8;
  localparam int unsigned HOST_ADDR_WIDTH     = 2;

  typedef struct packed {
    logic                           valid;
    logic                           bank_num;
    logic [REG_FILE_ADDR_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl3_reg_wr_t;

  typedef struct packed {
    logic                           bank_num;
    logic [REG_FILE_ADDR_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } host_wr_entry_t;

  localparam int unsigned HOST_WR_ENTRY_WIDTH = $bits(host_wr_entry_t);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } issue_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-2 depth; pushes into a full FIFO are dropped,
// pops from an empty FIFO are ignored. Head entry is presented combinationally.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CntW-1:0]       count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/opl3_host_port.sv
// Host side of the OPL3 register map: latches index writes, queues data writes and
// issues them downstream as single-cycle valid pulses spaced at least MIN_WR_GAP apart.
module opl3_host_port
  import opl3_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_WR_GAP = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [HOST_ADDR_WIDTH-1:0] host_addr,
  input  logic                       host_wr,
  input  logic                       host_rd,
  input  logic [7:0]                 host_din,
  output logic [7:0]                 host_dout,
  input  logic [7:0]                 status_in,
  output logic                       fifo_full,
  output logic                       overflow,
  output opl3_reg_wr_t               opl3_reg_wr
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GapW = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;
  localparam logic [GapW-1:0] GapReload = GapW'(MIN_WR_GAP - 1);

  // Reset asserts asynchronously but releases in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  logic [7:0]     index_reg_q, index_reg_d;
  logic           index_bank_q, index_bank_d;
  logic [7:0]     host_dout_q, host_dout_d;
  logic           overflow_q, overflow_d;
  issue_state_e   state_q, state_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  opl3_reg_wr_t   reg_wr_q, reg_wr_d;

  logic           data_wr, issue;
  logic           fifo_full_int, fifo_empty;
  logic [CntW-1:0] fifo_count;
  host_wr_entry_t push_entry, head_entry;

  assign data_wr = host_wr && host_addr[0];

  // Bank comes from the latched index, not from the data port address.
  always_comb begin
    push_entry.bank_num = index_bank_q;
    push_entry.address  = index_reg_q;
    push_entry.data     = host_din;
  end

  sync_fifo #(
    .DATA_WIDTH (HOST_WR_ENTRY_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n_int),
    .push_i  (data_wr),
    .wdata_i (push_entry),
    .pop_i   (issue),
    .rdata_o (head_entry),
    .full_o  (fifo_full_int),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    index_reg_d  = index_reg_q;
    index_bank_d = index_bank_q;
    if (host_wr && !host_addr[0]) begin
      index_reg_d  = host_din;
      index_bank_d = host_addr[1];
    end
    host_dout_d = host_dout_q;
    if (host_rd) begin
      host_dout_d = (host_addr == '0) ? status_in : 8'hFF;
    end
    overflow_d = data_wr && fifo_full_int;
  end

  // Pacing FSM: the ISSUE state is the cycle the valid pulse is on the output.
  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    reg_wr_d       = reg_wr_q;
    reg_wr_d.valid = 1'b0;
    issue          = 1'b0;
    unique case (state_q)
      StIdle: begin
        issue = !fifo_empty;
      end
      StIssue, StGap: begin
        if (MIN_WR_GAP == 1) begin
          issue   = !fifo_empty;
          state_d = StIdle;
        end else if (gap_cnt_q <= GapW'(1)) begin
          gap_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
          state_d   = StGap;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      reg_wr_d.valid    = 1'b1;
      reg_wr_d.bank_num = head_entry.bank_num;
      reg_wr_d.address  = head_entry.address;
      reg_wr_d.data     = head_entry.data;
      gap_cnt_d         = GapReload;
      state_d           = StIssue;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      index_reg_q  <= '0;
      index_bank_q <= 1'b0;
      host_dout_q  <= '0;
      overflow_q   <= 1'b0;
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      reg_wr_q     <= '0;
    end else begin
      index_reg_q  <= index_reg_d;
      index_bank_q <= index_bank_d;
      host_dout_q  <= host_dout_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      reg_wr_q     <= reg_wr_d;
    end
  end

  assign host_dout   = host_dout_q;
  assign overflow    = overflow_q;
  assign opl3_reg_wr = reg_wr_q;
  assign fifo_full   = (fifo_count == CntW'(FIFO_DEPTH));

endmodule

// File: tb/tb_opl3_host_port.sv
// Directed bench for opl3_host_port: reset, index/data writes, pacing, overflow,
// status reads and reset during an in-flight write.
module tb_opl3_host_port;
  import opl3_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   host_addr;
  logic         host_wr, host_rd;
  logic [7:0]   host_din, host_dout, status_in;
  logic         fifo_full, overflow;
  opl3_reg_wr_t opl3_reg_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  bit full_seen = 0;

  logic [7:0] q_data [$];
  logic [7:0] q_addr [$];
  logic       q_bank [$];
  int         q_cyc  [$];

  opl3_host_port #(
    .FIFO_DEPTH (8),
    .MIN_WR_GAP (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .host_addr   (host_addr),
    .host_wr     (host_wr),
    .host_rd     (host_rd),
    .host_din    (host_din),
    .host_dout   (host_dout),
    .status_in   (status_in),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .opl3_reg_wr (opl3_reg_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (opl3_reg_wr.valid) begin
      q_data.push_back(opl3_reg_wr.data);
      q_addr.push_back(opl3_reg_wr.address);
      q_bank.push_back(opl3_reg_wr.bank_num);
      q_cyc.push_back(cyc);
    end
    if (overflow)  ovf_cnt++;
    if (fifo_full) full_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    host_addr = a;
    host_din  = d;
    host_wr   = 1'b1;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_addr.delete();
    q_bank.delete();
    q_cyc.delete();
  endtask

  initial begin
    int wr_cyc;
    int qsz;
    reset_n   = 1'b0;
    host_addr = '0;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    host_din  = '0;
    status_in = '0;

    // Reset with random host activity
    for (int i = 0; i < 6; i++) begin
      host_addr = 2'($urandom_range(0, 3));
      host_din  = 8'($urandom);
      host_wr   = 1'($urandom);
      host_rd   = 1'($urandom);
      status_in = 8'($urandom);
      tick();
    end
    chk("rst_dout", 32'(host_dout), 32'h0);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_regwr", 32'(opl3_reg_wr), 32'h0);
    host_wr = 1'b0;
    host_rd = 1'b0;
    status_in = '0;
    clear_q();
    reset_n = 1'b1;
    repeat (8) tick();
    chk("rst_no_valid", 32'(q_data.size()), 32'd0);
    chk("rst_regwr_after", 32'(opl3_reg_wr), 32'h0);

    // Basic index/data write, bank 0
    clear_q();
    wr(2'd0, 8'hBD);
    wr(2'd1, 8'h20);
    wr_cyc = cyc;
    repeat (8) tick();
    chk("basic_cnt", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) begin
      chk("basic_bank", 32'(q_bank[0]), 32'd0);
      chk("basic_addr", 32'(q_addr[0]), 32'hBD);
      chk("basic_data", 32'(q_data[0]), 32'h20);
      chk("basic_lat", 32'(q_cyc[0]), 32'(wr_cyc + 1));
    end
    chk("hold_valid", 32'(opl3_reg_wr.valid), 32'd0);
    chk("hold_addr", 32'(opl3_reg_wr.address), 32'hBD);
    chk("hold_data", 32'(opl3_reg_wr.data), 32'h20);

    // Bank 1 index, data through addr 1
    clear_q();
    wr(2'd2, 8'h05);
    wr(2'd1, 8'h01);
    repeat (8) tick();
    chk("bank1_cnt", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) begin
      chk("bank1_bank", 32'(q_bank[0]), 32'd1);
      chk("bank1_addr", 32'(q_addr[0]), 32'h05);
      chk("bank1_data", 32'(q_data[0]), 32'h01);
    end

    // Pacing: 8 back-to-back data writes reusing one index
    clear_q();
    wr(2'd0, 8'h40);
    for (int i = 0; i < 8; i++) begin
      wr(2'd1, 8'(8'h10 + i));
      if (i == 0) wr_cyc = cyc;
    end
    repeat (40) tick();
    chk("pace_cnt", 32'(q_data.size()), 32'd8);
    if (q_data.size() == 8) begin
      chk("pace_first", 32'(q_cyc[0]), 32'(wr_cyc + 1));
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("pace_data%0d", i), 32'(q_data[i]), 32'(8'h10 + i));
        chk($sformatf("pace_addr%0d", i), 32'(q_addr[i]), 32'h40);
        chk($sformatf("pace_bank%0d", i), 32'(q_bank[i]), 32'd0);
        if (i > 0) chk($sformatf("pace_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd4);
      end
    end

    // Overflow: 13 back-to-back writes; pops at +1,+5,+9 leave writes 12 and 13 dropped
    clear_q();
    ovf_cnt   = 0;
    full_seen = 1'b0;
    for (int i = 0; i < 13; i++) wr(2'd1, 8'(8'h80 + i));
    repeat (60) tick();
    chk("ovf_full_seen", 32'(full_seen), 32'd1);
    chk("ovf_pulses", 32'(ovf_cnt), 32'd2);
    chk("ovf_issued", 32'(q_data.size()), 32'd11);
    if (q_data.size() == 11) begin
      for (int i = 0; i < 11; i++) begin
        chk($sformatf("ovf_data%0d", i), 32'(q_data[i]), 32'(8'h80 + i));
      end
    end
    chk("ovf_full_end", 32'(fifo_full), 32'd0);

    // Status reads
    status_in = 8'hE0;
    host_addr = 2'd0;
    host_rd   = 1'b1;
    tick();
    host_rd   = 1'b0;
    chk("stat_rd0", 32'(host_dout), 32'hE0);
    status_in = 8'h12;
    tick();
    chk("stat_hold", 32'(host_dout), 32'hE0);
    host_addr = 2'd1;
    host_rd   = 1'b1;
    tick();
    host_rd   = 1'b0;
    chk("stat_rd1", 32'(host_dout), 32'hFF);

    // Simultaneous read and write, both paths honoured
    clear_q();
    status_in = 8'hA0;
    host_rd   = 1'b1;
    wr(2'd0, 8'h33);
    chk("sim_rd0", 32'(host_dout), 32'hA0);
    wr(2'd1, 8'h44);
    host_rd   = 1'b0;
    chk("sim_rd1", 32'(host_dout), 32'hFF);
    repeat (8) tick();
    chk("sim_cnt", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) begin
      chk("sim_addr", 32'(q_addr[0]), 32'h33);
      chk("sim_data", 32'(q_data[0]), 32'h44);
    end

    // Reset while a write is on the output and more are queued
    clear_q();
    for (int i = 0; i < 3; i++) wr(2'd1, 8'(8'hC0 + i));
    for (int i = 0; i < 10; i++) begin
      if (opl3_reg_wr.valid) break;
      tick();
    end
    chk("mid_valid_seen", 32'(opl3_reg_wr.valid), 32'd1);
    qsz = q_data.size();
    reset_n = 1'b0;
    #1;
    chk("mid_regwr_clr", 32'(opl3_reg_wr), 32'h0);
    chk("mid_full_clr", 32'(fifo_full), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("mid_discard", 32'(q_data.size()), 32'(qsz));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
